mod6_counter: RTL and testbench

- Modulo-6 up/down counter in the standard tile wrapper: 8 dedicated inputs, 8 dedicated outputs, 8 bidirectional IOs.
- Supports count enable, direction, synchronous clear and parallel load.
- Presents the count as an active-high 7-segment pattern, as 3-bit binary, and with a wrap pulse and a 4-bit wrap tally.

---
 rtl/mod6_counter.sv | 100 ++++++++++
 tb/tb_mod6_counter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mod6_counter.sv
// Modulo-6 up/down counter tile: prescaled stepping, clear/load, 7-segment and
// binary views of the count, plus a one-cycle wrap pulse and a 4-bit wrap tally.
module mod6_counter #(
  parameter int DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic          count_en, dir, load, clear;
  logic [2:0]    load_val;

  logic [2:0]    count_q, count_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          wrap_q, wrap_d;
  logic [3:0]    tally_q, tally_d;
  logic [6:0]    seg;
  logic          unused_inputs;

  assign count_en = ui_in[0];
  assign dir      = ui_in[1];
  assign load     = ui_in[2];
  assign load_val = ui_in[5:3];
  assign clear    = ui_in[6];

  assign unused_inputs = ^{uio_in, ui_in[7]};

  always_comb begin
    count_d = count_q;
    pre_d   = pre_q;
    wrap_d  = wrap_q;
    tally_d = tally_q;
    if (ena) begin
      if (clear) begin
        count_d = 3'd0;
        pre_d   = '0;
        tally_d = 4'd0;
        wrap_d  = 1'b0;
      end else if (load) begin
        pre_d   = '0;
        wrap_d  = 1'b0;
        count_d = (load_val > 3'd5) ? 3'd0 : load_val;
      end else if (count_en && (pre_q == PRE_LAST)) begin
        pre_d = '0;
        if (!dir) begin
          wrap_d  = (count_q == 3'd5);
          count_d = (count_q == 3'd5) ? 3'd0 : count_q + 3'd1;
        end else begin
          wrap_d  = (count_q == 3'd0);
          count_d = (count_q == 3'd0) ? 3'd5 : count_q - 3'd1;
        end
        if (wrap_d) tally_d = tally_q + 4'd1;
      end else begin
        // Any enabled edge that does not wrap drops the pulse.
        if (count_en) pre_d = pre_q + PW'(1);
        wrap_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 3'd0;
      pre_q   <= '0;
      wrap_q  <= 1'b0;
      tally_q <= 4'd0;
    end else begin
      count_q <= count_d;
      pre_q   <= pre_d;
      wrap_q  <= wrap_d;
      tally_q <= tally_d;
    end
  end

  always_comb begin
    case (count_q)
      3'd0:    seg = 7'h3F;
      3'd1:    seg = 7'h06;
      3'd2:    seg = 7'h5B;
      3'd3:    seg = 7'h4F;
      3'd4:    seg = 7'h66;
      3'd5:    seg = 7'h6D;
      default: seg = 7'h00;
    endcase
  end

  assign uo_out  = {wrap_q, seg};
  assign uio_out = {tally_q, dir, count_q};
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_mod6_counter.sv
// Scoreboard bench: drives DIV=1 and DIV=3 counters in parallel from one stimulus
// stream, predicting each one's outputs with an independent behavioural model.
module tb_mod6_counter;

  logic       clk = 1'b0;
  logic       rst, ena;
  logic [7:0] ui_in, uio_in;
  logic [7:0] uo1, uio1, oe1, uo3, uio3, oe3;

  always #5 clk = ~clk;

  mod6_counter #(.DIV(1)) dut1 (
    .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo1), .uio_out(uio1), .uio_oe(oe1)
  );
  mod6_counter #(.DIV(3)) dut3 (
    .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo3), .uio_out(uio3), .uio_oe(oe3)
  );

  typedef struct {
    int cnt;
    int pre;
    int wrap;
    int tally;
  } st_t;

  typedef struct {
    logic [7:0] uo;
    logic [7:0] uio;
  } exp_t;

  st_t  m1, m3;
  exp_t q1[$], q3[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic st_t model(input st_t s, input int div, input logic r,
                                input logic e, input logic [7:0] ui);
    st_t n = s;
    if (r) begin
      n.cnt = 0; n.pre = 0; n.wrap = 0; n.tally = 0;
    end else if (!e) begin
      n = s;
    end else if (ui[6]) begin
      n.cnt = 0; n.pre = 0; n.wrap = 0; n.tally = 0;
    end else if (ui[2]) begin
      n.pre  = 0;
      n.wrap = 0;
      n.cnt  = (int'(ui[5:3]) > 5) ? 0 : int'(ui[5:3]);
    end else if (ui[0]) begin
      if (s.pre == div - 1) begin
        n.pre = 0;
        if (!ui[1]) begin
          n.wrap = (s.cnt == 5) ? 1 : 0;
          n.cnt  = (s.cnt + 1) % 6;
        end else begin
          n.wrap = (s.cnt == 0) ? 1 : 0;
          n.cnt  = (s.cnt + 5) % 6;
        end
        if (n.wrap == 1) n.tally = (s.tally + 1) % 16;
      end else begin
        n.pre  = s.pre + 1;
        n.wrap = 0;
      end
    end else begin
      n.wrap = 0;
    end
    return n;
  endfunction

  function automatic exp_t outputs(input st_t s, input logic [7:0] ui);
    exp_t x;
    logic [6:0] seg;
    case (s.cnt)
      0: seg = 7'h3F;
      1: seg = 7'h06;
      2: seg = 7'h5B;
      3: seg = 7'h4F;
      4: seg = 7'h66;
      5: seg = 7'h6D;
      default: seg = 7'h00;
    endcase
    x.uo  = {s.wrap[0], seg};
    x.uio = {s.tally[3:0], ui[1], s.cnt[2:0]};
    return x;
  endfunction

  task automatic drive(input logic r, input logic e, input logic [7:0] ui);
    exp_t x1, x3;
    rst    = r;
    ena    = e;
    ui_in  = ui;
    uio_in = 8'($urandom);
    m1 = model(m1, 1, r, e, ui);
    m3 = model(m3, 3, r, e, ui);
    q1.push_back(outputs(m1, ui));
    q3.push_back(outputs(m3, ui));
    @(posedge clk);
    #1;
    cyc++;
    x1 = q1.pop_front();
    x3 = q3.pop_front();
    check_eq("uo_div1", {24'd0, uo1}, {24'd0, x1.uo});
    check_eq("uio_div1", {24'd0, uio1}, {24'd0, x1.uio});
    check_eq("uo_div3", {24'd0, uo3}, {24'd0, x3.uo});
    check_eq("uio_div3", {24'd0, uio3}, {24'd0, x3.uio});
    $display("cyc %0d rst=%b ena=%b ui=%h | d1 uo=%h uio=%h | d3 uo=%h uio=%h",
             cyc, r, e, ui, uo1, uio1, uo3, uio3);
  endtask

  localparam logic [7:0] UP   = 8'b0000_0001;
  localparam logic [7:0] DOWN = 8'b0000_0011;
  localparam logic [7:0] IDLE = 8'b0000_0000;

  initial begin
    m1 = '{0, 0, 0, 0};
    m3 = '{0, 0, 0, 0};
    rst = 1'b1; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;

    drive(1, 1, IDLE);
    drive(1, 1, IDLE);
    check_eq("reset_uo", {24'd0, uo1}, 32'h3F);
    check_eq("reset_oe", {24'd0, oe1}, 32'hFF);
    for (int i = 0; i < 4; i++) drive(0, 1, IDLE);
    check_eq("idle_uio", {24'd0, uio1}, 32'h00);

    for (int i = 0; i < 7; i++) drive(0, 1, UP);
    check_eq("up7_count", {29'd0, uio1[2:0]}, 32'd1);
    check_eq("up7_tally", {28'd0, uio1[7:4]}, 32'd1);

    drive(0, 1, 8'b0000_0100);          // load 0
    drive(0, 1, DOWN);
    check_eq("down_wrap_pulse", {31'd0, uo1[7]}, 32'd1);
    check_eq("down_wrap_count", {29'd0, uio1[2:0]}, 32'd5);
    drive(0, 1, DOWN);
    check_eq("down_tally", {28'd0, uio1[7:4]}, 32'd2);

    drive(0, 1, 8'b0001_1100);          // load 3
    check_eq("load3_seg", {25'd0, uo1[6:0]}, 32'h4F);
    drive(0, 1, 8'b0011_1100);          // load 7 -> 0
    check_eq("load7_count", {29'd0, uio1[2:0]}, 32'd0);
    drive(0, 1, 8'b0110_1100);          // load 5 with clear
    check_eq("clear_tally", {28'd0, uio1[7:4]}, 32'd0);

    for (int i = 0; i < 3; i++) drive(0, 1, UP);
    for (int i = 0; i < 3; i++) drive(0, 0, UP);
    check_eq("ena0_frozen", {29'd0, uio1[2:0]}, 32'd3);
    drive(0, 1, UP);
    drive(1, 1, UP);
    check_eq("rst_mid_count", {24'd0, uio1 & 8'hF7}, 32'd0);

    for (int i = 0; i < 9; i++) drive(0, 1, UP);
    check_eq("div3_count", {29'd0, uio3[2:0]}, 32'd3);

    drive(1, 1, IDLE);
    for (int i = 0; i < 96; i++) drive(0, 1, UP);
    check_eq("tally_roll", {28'd0, uio1[7:4]}, 32'd0);

    for (int i = 0; i < 300; i++) begin
      logic [7:0] ui;
      ui = 8'($urandom);
      if ($urandom_range(0, 3) != 0) ui[6] = 1'b0;
      if ($urandom_range(0, 3) != 0) ui[2] = 1'b0;
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 7) != 0, ui);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
